// File: rtl/ex_muldiv_pkg.sv
// Shared constants for the RV32M multiply/divide unit: funct3 op codes,
// the M-extension funct7, FSM state encodings and common zero/enable values.
package ex_muldiv_pkg;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  localparam logic [6:0] INST_M_FUNCT7 = 7'b0000001;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [31:0] ZERO_WORD     = 32'h0000_0000;
  localparam logic [4:0]  ZERO_REG      = 5'd0;
  localparam logic        WRITE_ENABLE  = 1'b1;
  localparam logic        WRITE_DISABLE = 1'b0;

endpackage

// File: rtl/ex_muldiv_div_step.sv
// One combinational restoring-division step: shifts the next dividend bit
// into the partial remainder and subtracts the divisor when it fits.
module ex_muldiv_div_step #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rem_i,
  input  logic            dividend_bit_i,
  input  logic [XLEN-1:0] divisor_i,
  output logic [XLEN-1:0] rem_o,
  output logic            q_bit_o
);

  logic [XLEN:0] shifted;
  logic [XLEN:0] diff;

  // The remainder is always below the divisor, so the shifted value fits in XLEN+1 bits.
  assign shifted = {rem_i, dividend_bit_i};
  assign diff    = shifted - {1'b0, divisor_i};
  assign q_bit_o = ~diff[XLEN];
  assign rem_o   = q_bit_o ? diff[XLEN-1:0] : shifted[XLEN-1:0];

endmodule

// File: rtl/ex_muldiv.sv
// EX-stage RV32M multiply/divide unit: iterative shift-add multiply and restoring divide.
// Defining MULDIV_FAST_MUL_EN replaces the iterative multiply with a single-cycle product.
module ex_muldiv
  import ex_muldiv_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start_i,
  input  logic [2:0]      funct3_i,
  input  logic [XLEN-1:0] op1_i,
  input  logic [XLEN-1:0] op2_i,
  input  logic [4:0]      reg_waddr_i,
  input  logic            abort_i,
  output logic            hold_req_o,
  output logic            busy_o,
  output logic [XLEN-1:0] result_o,
  output logic            result_valid_o,
  output logic [4:0]      reg_waddr_o,
  output logic            reg_wen_o
);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0]  a_q, a_d;
  logic [XLEN-1:0]  b_q, b_d;
  logic [XLEN-1:0]  r_q, r_d;
  logic             neg_q, neg_d;
  logic [2:0]       funct3_q, funct3_d;
  logic [4:0]       waddr_q, waddr_d;

  logic            signed1, signed2, neg1, neg2, neg_sel;
  logic [XLEN-1:0] mag1, mag2;
  logic            is_div_i, div_by_zero, div_ovf;
  logic [XLEN:0]   mul_sum;
  logic [XLEN-1:0] step_rem;
  logic            step_q;

  always_comb begin
    signed1     = funct3_i inside {F3_MUL, F3_MULH, F3_MULHSU, F3_DIV, F3_REM};
    signed2     = funct3_i inside {F3_MUL, F3_MULH, F3_DIV, F3_REM};
    neg1        = signed1 & op1_i[XLEN-1];
    neg2        = signed2 & op2_i[XLEN-1];
    mag1        = neg1 ? -op1_i : op1_i;
    mag2        = neg2 ? -op2_i : op2_i;
    neg_sel     = (funct3_i == F3_REM) ? neg1 : (neg1 ^ neg2);
    is_div_i    = funct3_i[2];
    div_by_zero = (op2_i == '0);
    div_ovf     = ~funct3_i[0] & (op1_i == {1'b1, {(XLEN-1){1'b0}}}) & (op2_i == '1);
  end

`ifdef MULDIV_FAST_MUL_EN
  logic [2*XLEN-1:0] fast_prod;
  assign fast_prod = {{XLEN{1'b0}}, mag1} * {{XLEN{1'b0}}, mag2};
`endif

  assign mul_sum = {1'b0, r_q} + (b_q[0] ? {1'b0, a_q} : '0);

  ex_muldiv_div_step #(.XLEN(XLEN)) u_div_step (
    .rem_i          (r_q),
    .dividend_bit_i (b_q[XLEN-1]),
    .divisor_i      (a_q),
    .rem_o          (step_rem),
    .q_bit_o        (step_q)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_d      = a_q;
    b_d      = b_q;
    r_d      = r_q;
    neg_d    = neg_q;
    funct3_d = funct3_q;
    waddr_d  = waddr_q;
    case (state_q)
      ST_IDLE: begin
        if (start_i && !abort_i) begin
          funct3_d = funct3_i;
          waddr_d  = reg_waddr_i;
          neg_d    = neg_sel;
          cnt_d    = CNT_W'(XLEN-1);
          if (is_div_i) begin
            // Corner cases are preloaded so the normal fix-up in DONE yields the final value.
            if (div_by_zero) begin
              b_d     = '1;
              r_d     = op1_i;
              neg_d   = 1'b0;
              state_d = ST_DONE;
            end else if (div_ovf) begin
              b_d     = {1'b1, {(XLEN-1){1'b0}}};
              r_d     = '0;
              neg_d   = 1'b0;
              state_d = ST_DONE;
            end else begin
              a_d     = mag2;
              b_d     = mag1;
              r_d     = '0;
              state_d = ST_CALC;
            end
          end else begin
`ifdef MULDIV_FAST_MUL_EN
            {r_d, b_d} = fast_prod;
            state_d    = ST_DONE;
`else
            a_d     = mag1;
            b_d     = mag2;
            r_d     = '0;
            state_d = ST_CALC;
`endif
          end
        end
      end
      ST_CALC: begin
        if (funct3_q[2]) begin
          r_d = step_rem;
          b_d = {b_q[XLEN-2:0], step_q};
        end else begin
          r_d = mul_sum[XLEN:1];
          b_d = {mul_sum[0], b_q[XLEN-1:1]};
        end
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == '0) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (abort_i) state_d = ST_IDLE;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      r_q      <= '0;
      neg_q    <= 1'b0;
      funct3_q <= 3'b000;
      waddr_q  <= ZERO_REG;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_q      <= a_d;
      b_q      <= b_d;
      r_q      <= r_d;
      neg_q    <= neg_d;
      funct3_q <= funct3_d;
      waddr_q  <= waddr_d;
    end
  end

  logic [XLEN-1:0]   div_raw, div_res, mul_res;
  logic [2*XLEN-1:0] prod_fix;

  // {r_q, b_q} holds the product magnitude for multiplies and {remainder, quotient} for divides.
  always_comb begin
    div_raw  = funct3_q[1] ? r_q : b_q;
    div_res  = neg_q ? -div_raw : div_raw;
    prod_fix = neg_q ? -{r_q, b_q} : {r_q, b_q};
    mul_res  = (funct3_q == F3_MUL) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];
  end

  assign busy_o         = (state_q != ST_IDLE);
  assign hold_req_o     = ~abort_i & (((state_q == ST_IDLE) & start_i) | (state_q == ST_CALC));
  assign result_valid_o = (state_q == ST_DONE);
  assign reg_wen_o      = (state_q == ST_DONE) ? WRITE_ENABLE : WRITE_DISABLE;
  assign reg_waddr_o    = waddr_q;
  assign result_o       = (state_q != ST_DONE) ? XLEN'(ZERO_WORD)
                        : (funct3_q[2] ? div_res : mul_res);

endmodule
